matrix_result_reader: RTL

//  Read-side companion of the 3x3 matrix multiply datapath. On start, waits out the multiply

---
 rtl/mat_acc_pkg.sv | 20 ++
 rtl/matrix_result_reader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/mat_acc_pkg.sv
// Shared types for the 3x3 matrix multiply result reader.
// Element/index types, default sizes and the reader FSM states.
package mat_acc_pkg;

  localparam int DEF_MAT_SIZE = 3;
  localparam int DEF_DAT_W    = 16;
  localparam int MAX_ELEM     = 1024;

  typedef logic [DEF_DAT_W-1:0] elem_t;
  typedef logic [9:0]           idx_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    STREAM = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4
  } rd_state_e;

endpackage

// File: rtl/matrix_result_reader.sv
// Snapshots mat_C after the multiply latency and streams it row-major.
// Optional trailing checksum beat: define MATRIX_READER_CHKSUM_EN.
module matrix_result_reader
  import mat_acc_pkg::*;
#(
  parameter int MAT_SIZE = DEF_MAT_SIZE,
  parameter int DAT_W    = DEF_DAT_W,
  parameter int CALC_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic [MAX_ELEM-1:0][15:0]  mat_C_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       m_valid_o,
  input  logic                       m_ready_i,
  output logic [DAT_W-1:0]           m_data_o,
  output idx_t                       m_idx_o,
  output logic                       m_last_o
);

  localparam int   NE   = MAT_SIZE * MAT_SIZE;
  localparam int   BW   = (NE > 1) ? $clog2(NE) : 1;
  localparam idx_t LAST = idx_t'(NE - 1);
`ifdef MATRIX_READER_CHKSUM_EN
  localparam bit HAS_CSUM = 1'b1;
`else
  localparam bit HAS_CSUM = 1'b0;
`endif

  rd_state_e               state;
  logic [15:0]             lat_q;
  logic [NE-1:0][DAT_W-1:0] buf_q;
  idx_t                    nxt;
  logic                    xfer;
  logic [BW-1:0]           cur_sel;
  logic                    unused_bits;

`ifdef MATRIX_READER_CHKSUM_EN
  logic [DAT_W-1:0] sum_q;
`endif

  assign nxt     = m_idx_o + 10'd1;
  assign xfer    = m_valid_o && m_ready_i;
  assign cur_sel = m_idx_o[BW-1:0];

  // Only the first NE elements of the flat bus are ever captured.
  assign unused_bits = ^mat_C_i;

  always_comb begin
    m_data_o = '0;
`ifdef MATRIX_READER_CHKSUM_EN
    if (state == CSUM)
      m_data_o = sum_q;
    else if (m_valid_o)
      m_data_o = buf_q[cur_sel];
`else
    if (m_valid_o)
      m_data_o = buf_q[cur_sel];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lat_q     <= '0;
      buf_q     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      m_valid_o <= 1'b0;
      m_idx_o   <= '0;
      m_last_o  <= 1'b0;
`ifdef MATRIX_READER_CHKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start_i) begin
            state  <= WAIT;
            lat_q  <= 16'(CALC_LAT - 1);
            busy_o <= 1'b1;
          end
        end
        WAIT: begin
          if (lat_q == '0) begin
            for (int k = 0; k < NE; k++)
              buf_q[k] <= mat_C_i[k][DAT_W-1:0];
            m_valid_o <= 1'b1;
            m_idx_o   <= '0;
            m_last_o  <= (NE == 1) && !HAS_CSUM;
            state     <= STREAM;
`ifdef MATRIX_READER_CHKSUM_EN
            sum_q     <= '0;
`endif
          end else begin
            lat_q <= lat_q - 16'd1;
          end
        end
        STREAM: begin
          if (xfer) begin
`ifdef MATRIX_READER_CHKSUM_EN
            sum_q <= sum_q + m_data_o;
`endif
            if (m_idx_o == LAST) begin
`ifdef MATRIX_READER_CHKSUM_EN
              m_idx_o  <= idx_t'(NE);
              m_last_o <= 1'b1;
              state    <= CSUM;
`else
              m_valid_o <= 1'b0;
              m_last_o  <= 1'b0;
              busy_o    <= 1'b0;
              done_o    <= 1'b1;
              state     <= DONE;
`endif
            end else begin
              m_idx_o  <= nxt;
              m_last_o <= (nxt == LAST) && !HAS_CSUM;
            end
          end
        end
        CSUM: begin
          if (xfer) begin
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
